// File: rtl/updown_counter_mod.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : updown_counter_mod
// Purpose  : Parametrised modulo up/down counter with load, clear, step and
//            programmable inclusive upper bound. Optional saturation mode is
//            built when UDCNT_SAT_EN is defined (adds the sat port).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module updown_counter_mod #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              ld,
   input  logic [WIDTH-1:0]  d,
   input  logic              en,
   input  logic              up,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  max,
`ifdef UDCNT_SAT_EN
   input  logic              sat,
`endif
   output logic [WIDTH-1:0]  q,
   output logic              at_max,
   output logic              at_zero,
   output logic              wrap
);

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;

   logic [WIDTH:0]   w_step_ext;
   logic [WIDTH:0]   w_q_ext;
   logic [WIDTH:0]   w_max_ext;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic             w_above_max;
   logic             w_ovf;
   logic             w_unf;
   logic             w_sat_mode;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_wrap_nxt;

`ifdef UDCNT_SAT_EN
   assign w_sat_mode = sat;
`else
   assign w_sat_mode = 1'b0;
`endif

   // Arithmetic is done one bit wider so the carry/borrow is visible.
   assign w_step_ext  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
   assign w_q_ext     = {1'b0, r_q};
   assign w_max_ext   = {1'b0, max};
   assign w_sum       = w_q_ext + w_step_ext;
   assign w_diff      = w_q_ext - w_step_ext;
   assign w_above_max = (r_q > max);
   assign w_ovf       = w_above_max || (w_sum > w_max_ext);
   assign w_unf       = (w_step_ext > w_q_ext);

   always_comb begin
      w_q_nxt    = r_q;
      w_wrap_nxt = 1'b0;
      if (clr) begin
         w_q_nxt = '0;
      end else if (ld) begin
         w_q_nxt = (d > max) ? max : d;
      end else if (en) begin
         if (up) begin
            if (w_ovf) begin
               w_q_nxt    = w_sat_mode ? max : '0;
               w_wrap_nxt = 1'b1;
            end else begin
               w_q_nxt = w_sum[WIDTH-1:0];
            end
         end else begin
            // A count stranded above a lowered bound re-enters at the top.
            if (w_above_max) begin
               w_q_nxt    = max;
               w_wrap_nxt = 1'b1;
            end else if (w_unf) begin
               w_q_nxt    = w_sat_mode ? '0 : max;
               w_wrap_nxt = 1'b1;
            end else begin
               w_q_nxt = w_diff[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q    <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_q    <= w_q_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign q       = r_q;
   assign wrap    = r_wrap;
   assign at_max  = (r_q == max);
   assign at_zero = (r_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_mod.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_updown_counter_mod
// Purpose  : Scoreboard bench for updown_counter_mod: directed scenarios plus
//            randomized traffic against an integer reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_updown_counter_mod;

   localparam int WIDTH  = 8;
   localparam int STEP_W = 4;
`ifdef UDCNT_SAT_EN
   localparam bit HAS_SAT = 1'b1;
`else
   localparam bit HAS_SAT = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clr, ld, en, up, sat;
   logic [WIDTH-1:0]  d, max;
   logic [STEP_W-1:0] step;
   logic [WIDTH-1:0]  q;
   logic              at_max, at_zero, wrap;

   always #5 clk = ~clk;

   updown_counter_mod #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .ld      (ld),
      .d       (d),
      .en      (en),
      .up      (up),
      .step    (step),
      .max     (max),
`ifdef UDCNT_SAT_EN
      .sat     (sat),
`endif
      .q       (q),
      .at_max  (at_max),
      .at_zero (at_zero),
      .wrap    (wrap)
   );

   typedef struct {
      int    q;
      bit    wrap;
      int    mx;
      string tag;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   m_q      = 0;
   bit   m_wrap   = 1'b0;

   function automatic void check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference behaviour in plain integer arithmetic.
   function automatic void model(bit c, bit l, int dv, bit e, bit u, int st, int mx, bit s);
      bit sm = HAS_SAT && s;
      if (c) begin
         m_q = 0; m_wrap = 0;
      end else if (l) begin
         m_q = (dv > mx) ? mx : dv; m_wrap = 0;
      end else if (e && u) begin
         if (m_q > mx || m_q + st > mx) begin
            m_q = sm ? mx : 0; m_wrap = 1;
         end else begin
            m_q = m_q + st; m_wrap = 0;
         end
      end else if (e) begin
         if (m_q > mx) begin
            m_q = mx; m_wrap = 1;
         end else if (st > m_q) begin
            m_q = sm ? 0 : mx; m_wrap = 1;
         end else begin
            m_q = m_q - st; m_wrap = 0;
         end
      end else begin
         m_wrap = 0;
      end
   endfunction

   task automatic drive(bit c, bit l, int dv, bit e, bit u, int st, int mx, bit s, string tag);
      exp_t x;
      @(negedge clk);
      clr  = c;
      ld   = l;
      d    = WIDTH'(dv);
      en   = e;
      up   = u;
      step = STEP_W'(st);
      max  = WIDTH'(mx);
      sat  = s;
      model(c, l, dv, e, u, st, mx, s);
      x.q = m_q; x.wrap = m_wrap; x.mx = mx; x.tag = tag;
      sbq.push_back(x);
      @(posedge clk);
   endtask

   // Monitor: every active edge presents a new count; compare with the queue head.
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (rst_n && sbq.size() > 0) begin
         x = sbq.pop_front();
         check({x.tag, ".q"},       int'(q),       x.q);
         check({x.tag, ".wrap"},    int'(wrap),    int'(x.wrap));
         check({x.tag, ".at_max"},  int'(at_max),  int'(x.q == x.mx));
         check({x.tag, ".at_zero"}, int'(at_zero), int'(x.q == 0));
      end
   end

   initial begin
      int mx;
      rst_n = 1'b0; clr = 0; ld = 0; en = 0; up = 0; sat = 0;
      d = '0; step = '0; max = 8'd9;
      #23;
      check("rst.q",       int'(q),       0);
      check("rst.wrap",    int'(wrap),    0);
      check("rst.at_zero", int'(at_zero), 1);
      check("rst.at_max",  int'(at_max),  0);
      max = 8'd0;
      #1;
      check("rst.at_max_max0", int'(at_max), 1);
      max = 8'd9;
      @(negedge clk);
      rst_n = 1'b1;
      m_q = 0; m_wrap = 0;

      repeat (2) drive(0, 0, 0, 0, 1, 1, 9, 0, "hold");
      repeat (10) drive(0, 0, 0, 1, 1, 1, 9, 0, "up1");

      drive(0, 1, 5, 0, 0, 3, 9, 0, "ld5");
      repeat (6) drive(0, 0, 0, 1, 0, 3, 9, 0, "dn3");

      drive(0, 1, 4, 0, 0, 0, 9, 0, "ld4");
      drive(1, 1, 7, 1, 1, 1, 9, 0, "prio_clr");
      drive(0, 1, 12, 1, 1, 1, 9, 0, "prio_ld");

      drive(0, 0, 0, 1, 1, 0, 9, 0, "step0");
      drive(0, 0, 0, 1, 1, 5, 6, 0, "above_up");
      drive(0, 1, 8, 0, 0, 0, 9, 0, "ld8");
      drive(0, 0, 0, 1, 0, 2, 3, 0, "above_dn");

      drive(1, 0, 0, 0, 0, 0, 0, 0, "clr0");
      repeat (2) drive(0, 0, 0, 1, 1, 3, 0, 0, "max0_up");
      repeat (2) drive(0, 0, 0, 1, 0, 3, 0, 0, "max0_dn");

      drive(0, 1, 250, 0, 0, 0, 255, 0, "ld250");
      repeat (2) drive(0, 0, 0, 1, 1, 15, 255, 0, "full_up");

`ifdef UDCNT_SAT_EN
      drive(0, 1, 190, 0, 1, 15, 200, 1, "sat_ld");
      repeat (3) drive(0, 0, 0, 1, 1, 15, 200, 1, "sat_up");
      drive(0, 1, 10, 0, 0, 15, 200, 1, "sat_ld10");
      repeat (2) drive(0, 0, 0, 1, 0, 15, 200, 1, "sat_dn");
`endif

      // Asynchronous reset between edges must clear the count at once.
      drive(0, 1, 7, 0, 0, 0, 9, 0, "ld7");
      #3;
      rst_n = 1'b0;
      #1;
      check("async.q",       int'(q),       0);
      check("async.wrap",    int'(wrap),    0);
      check("async.at_zero", int'(at_zero), 1);
      @(negedge clk);
      rst_n = 1'b1;
      m_q = 0; m_wrap = 0;

      for (int i = 0; i < 500; i++) begin
         case ($urandom_range(0, 3))
            0:       mx = 0;
            1:       mx = 255;
            2:       mx = int'($urandom_range(0, 20));
            default: mx = int'($urandom_range(0, 255));
         endcase
         drive($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
               int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), mx,
               1'($urandom_range(0, 1)), "rand");
      end

      #2;
      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
      #2;
      if (sbq.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
